// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl
// Purpose  : In-order issue gate with a register scoreboard, outstanding-load
//            limit and fence drain.
// Revision : 1.0
// ============================================================================
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        ex_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic [31:0] pending_o,
  output logic [3:0]  inflight_o
);

  localparam logic [3:0] c_MAX_INFL = 4'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pending;
  logic [3:0]  r_inflight;

  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_is_load;
  logic        w_is_fence;
  logic [31:0] w_wb_mask;
  logic [31:0] w_pend_eff;
  logic [31:0] w_set_mask;
  logic [31:0] w_pending_nxt;
  logic        w_wb_dec;
  logic [3:0]  w_inflight_eff;
  logic [3:0]  w_inflight_nxt;
  logic        w_hazard;
  logic        w_full;
  logic        w_issue;
  logic        w_load_issue;

  assign w_uses_rs1 = (opcode_i == 7'b0110011) || (opcode_i == 7'b0010011) ||
                      (opcode_i == 7'b0000011) || (opcode_i == 7'b0100011) ||
                      (opcode_i == 7'b1100011) || (opcode_i == 7'b1100111);
  assign w_uses_rs2 = (opcode_i == 7'b0110011) || (opcode_i == 7'b0100011) ||
                      (opcode_i == 7'b1100011);
  assign w_is_load  = (opcode_i == 7'b0000011);
  assign w_is_fence = (opcode_i == 7'b0001111);

  // A same-cycle writeback already resolves its register, so look through it.
  assign w_wb_mask  = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
  assign w_pend_eff = r_pending & ~w_wb_mask;

  assign w_wb_dec       = wb_valid_i && (r_inflight != 4'd0);
  assign w_inflight_eff = r_inflight - {3'b000, w_wb_dec};

  assign w_hazard = (w_uses_rs1 && (rs1_i != 5'd0) && w_pend_eff[rs1_i]) ||
                    (w_uses_rs2 && (rs2_i != 5'd0) && w_pend_eff[rs2_i]) ||
                    (w_is_load  && (rd_i  != 5'd0) && w_pend_eff[rd_i]);
  assign w_full   = w_is_load && (w_inflight_eff == c_MAX_INFL);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = dec_valid_i && ex_ready_i && !flush_i && !w_hazard && !w_full &&
                  !(w_is_fence && (w_inflight_eff != 4'd0));
        if (dec_valid_i && w_is_fence && (w_inflight_eff != 4'd0) && !flush_i)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((w_inflight_eff == 4'd0) || flush_i)
          w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Gated by rst so the combinational outputs also drop during reset.
  assign issue_o = rst && w_issue;
  assign stall_o = rst && dec_valid_i && !w_issue && !flush_i;

  assign w_load_issue   = w_issue && w_is_load;
  assign w_set_mask     = (w_load_issue && (rd_i != 5'd0)) ? (32'd1 << rd_i) : 32'd0;
  assign w_pending_nxt  = ((r_pending & ~w_wb_mask) | w_set_mask) & ~32'd1;
  assign w_inflight_nxt = r_inflight + {3'b000, w_load_issue} - {3'b000, w_wb_dec};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_pending  <= 32'd0;
      r_inflight <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign pending_o  = r_pending;
  assign inflight_o = r_inflight;

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of outstanding loads (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock.
REQ-003 The block SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port dec_valid_i, input, 1, meaning the decode stage holds a valid instruction.
REQ-005 The block SHALL have ports opcode_i (7), rs1_i (5), rs2_i (5) and rd_i (5), all inputs, carrying the decoded fields of the current instruction.
REQ-006 The block SHALL have port ex_ready_i, input, 1, meaning the execute stage accepts an instruction this cycle.
REQ-007 The block SHALL have ports wb_valid_i (input, 1) and wb_rd_i (input, 5), meaning a load writeback to register wb_rd_i completes this cycle.
REQ-008 The block SHALL have port flush_i, input, 1, meaning a redirect that kills the instruction currently in decode.
REQ-009 The block SHALL have port issue_o, output, 1, meaning the decode instruction transfers to execute this cycle.
REQ-010 The block SHALL have port stall_o, output, 1, meaning hold the fetch and decode registers this cycle.
REQ-011 The block SHALL have ports pending_o (output, 32), the scoreboard bitmap, and inflight_o (output, 4), the outstanding load count.

Function
REQ-012 Register use SHALL be decoded from opcode_i as follows.
- uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- uses_rs2: 0110011, 0100011, 1100011.
- is_load: 0000011.
- is_fence: 0001111.
REQ-013 The effective pending vector SHALL be pend_eff = pending & ~(wb_valid_i ? onehot(wb_rd_i) : 0); writeback in the same cycle clears a hazard combinationally.
REQ-014 The hazard signal SHALL be asserted when any of the following holds.
- uses_rs1, rs1_i != 0 and pend_eff[rs1_i].
- uses_rs2, rs2_i != 0 and pend_eff[rs2_i].
- is_load, rd_i != 0 and pend_eff[rd_i] (WAW).
REQ-015 The full signal SHALL be is_load && (inflight - (wb_valid_i && inflight != 0)) == MAX_INFLIGHT.
REQ-016 The FSM SHALL have two states, RUN and DRAIN, and SHALL reset to RUN.
REQ-017 In RUN, issue_o SHALL equal dec_valid_i & ex_ready_i & ~flush_i & ~hazard & ~full & ~(is_fence & inflight_eff != 0), where inflight_eff is the count after the same-cycle writeback.
REQ-018 In RUN, the FSM SHALL move to DRAIN when dec_valid_i & is_fence & inflight_eff != 0 & ~flush_i.
REQ-019 In DRAIN, issue_o SHALL be 0.
REQ-020 In DRAIN, the FSM SHALL move to RUN when inflight_eff == 0 or flush_i; the fence then issues in RUN on the following cycle, subject to REQ-017.
REQ-021 stall_o SHALL equal dec_valid_i & ~issue_o & ~flush_i; flush_i SHALL never assert stall_o.
REQ-022 issue_o and stall_o SHALL be combinational from the inputs and registered state; pending and inflight SHALL update on the rising edge of clk.
REQ-023 On issue of a load with rd_i != 0, pending[rd_i] SHALL be set next cycle.
REQ-024 On wb_valid_i, pending[wb_rd_i] SHALL be cleared next cycle.
REQ-025 If set and clear target the same register in one cycle, set SHALL win.
REQ-026 On each cycle, inflight SHALL change by +1 for an issued load (including rd == 0) and -1 for wb_valid_i.
REQ-027 A wb_valid_i arriving when inflight == 0 SHALL not decrement inflight (no underflow); the pending clear SHALL still apply.
REQ-028 flush_i SHALL NOT clear pending or inflight, because loads already issued still complete.
REQ-029 pending[0] SHALL always read 0.

Reset
REQ-030 While rst = 0, pending_o, inflight_o, issue_o and stall_o SHALL be 0 and the state SHALL be RUN, asynchronously.
REQ-031 After rst deasserts, the first issue SHALL be possible on the first rising clk edge.
REQ-032 Reset asserted mid-DRAIN or with loads outstanding SHALL discard all tracking state.

Verification
REQ-033 The bench SHALL cover a load-use case.
- Stimulus: load x5 issues at cycle 0, then add x6,x5,x1 is presented at cycle 1 with no wb.
- Required: stall_o = 1 and issue_o = 0.
- Stimulus: wb_valid_i with wb_rd_i = 5 at cycle 3.
- Required: issue_o = 1 in cycle 3.
REQ-034 The bench SHALL cover the full limit.
- Stimulus: MAX_INFLIGHT = 4 and four loads to x1..x4 issued with no wb.
- Required: inflight_o = 4 and a fifth load to x7 stalls.
- Stimulus: same-cycle wb of x1.
- Required: the fifth load issues and inflight_o stays 4.
REQ-035 The bench SHALL cover fence drain.
- Stimulus: 2 loads outstanding when a fence is presented.
- Required: DRAIN with stall_o = 1.
- Stimulus: both wbs complete.
- Required: fence issue_o = 1 on the cycle after inflight reaches 0.
REQ-036 The bench SHALL cover flush.
- Stimulus: flush_i asserted while a hazard stall is in progress on x5.
- Required: issue_o = 0, stall_o = 0, pending_o[5] still 1.
REQ-037 The bench SHALL cover x0 and underflow.
- Stimulus: load to x0.
- Required: pending_o unchanged and inflight_o + 1.
- Stimulus: spurious wb at inflight = 0.
- Required: inflight_o stays 0.
REQ-038 The bench SHALL cover asynchronous reset.
- Stimulus: rst = 0 pulsed mid-DRAIN with 3 loads outstanding.
- Required: outputs go to 0 immediately, and the next add issues on the first edge after release.
